adc_scan_sequencer: RTL and testbench

Round-robin channel scheduler for the 8-channel SPI ADC front end. It sits between the application logic and the ADC SPI controller. It builds the 6-bit per-conversion configuration word, fires one conversion at a time through a start/done handshake, and accounts for the ADC's one-frame result latency. Results land in a per-channel result bank with valid flags that application logic can read.

---
 rtl/adc_pkg.sv | 16 +
 rtl/adc_rr_pick.sv | 38 +++
 rtl/adc_scan_sequencer.sv | 129 ++++++++++++
 tb/tb_adc_scan_sequencer.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// Shared state type, sizes and configuration-word builder for the ADC scan sequencer.
package adc_pkg;

  localparam int CONF_W = 6;
  localparam int NUM_CH = 8;

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY, GAP} state_t;

  // Field order S/D, O/S, S1, S0, UNI, SLP; S/D is tied high (single-ended only).
  function automatic logic [CONF_W-1:0] adc_conf(input logic [2:0] ch,
                                                 input logic       uni,
                                                 input logic       slp);
    return {1'b1, ch[0], ch[2], ch[1], uni, slp};
  endfunction

endpackage

// File: rtl/adc_rr_pick.sv
// Round-robin channel picker: next enabled channel after cur (cur itself last),
// highest enabled channel, and an empty-mask flag.
module adc_rr_pick
  import adc_pkg::*;
(
  input  logic [NUM_CH-1:0] mask,
  input  logic [2:0]        cur,
  output logic [2:0]        next,
  output logic [2:0]        last,
  output logic              none
);

  logic [NUM_CH-1:0] rot;
  logic [2:0]        off;

  // rot[k] is the mask bit k+1 places after cur; k = 7 wraps onto cur itself.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_rot
      assign rot[gi] = mask[3'(cur + 3'(gi + 1))];
    end
  endgenerate

  always_comb begin
    off  = '0;
    last = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (rot[i]) off = 3'(i);
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (mask[i]) last = 3'(i);
    end
  end

  assign next = cur + off + 3'd1;
  assign none = (mask == '0);

endmodule

// File: rtl/adc_scan_sequencer.sv
// Round-robin scan sequencer for the 8-channel pipelined SPI ADC: issues one
// conversion at a time and files each result under the channel it belongs to.
module adc_scan_sequencer
  import adc_pkg::*;
#(
  parameter int GAP_CYCLES = 16,
  parameter int TIMEOUT    = 1023,
  parameter int DATA_W     = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              scan_en,
  input  logic [NUM_CH-1:0] ch_mask,
  input  logic              uni,
  input  logic              slp,
  output logic              conv_start,
  output logic [CONF_W-1:0] conv_conf,
  input  logic              conv_done,
  input  logic [DATA_W-1:0] conv_data,
  input  logic [2:0]        rd_ch,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              scan_done,
  output logic              busy,
  output logic              timeout_err
);

  localparam int CNT_MAX = (TIMEOUT > GAP_CYCLES) ? TIMEOUT : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

  state_t            state, state_next;
  logic [2:0]        cur_ch, prev_ch;
  logic              primed;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] result [NUM_CH];
  logic [NUM_CH-1:0] valid;

  logic [2:0] pick_cur, pick_next, pick_last;
  logic       pick_none;

  // From IDLE, searching after channel 7 yields the lowest enabled channel.
  assign pick_cur = (state == IDLE) ? 3'd7 : cur_ch;

  adc_rr_pick u_pick (
    .mask (ch_mask),
    .cur  (pick_cur),
    .next (pick_next),
    .last (pick_last),
    .none (pick_none)
  );

  always_comb begin
    state_next = state;
    conv_start = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE:  if (scan_en && ch_mask != '0) state_next = ISSUE;
      ISSUE: begin
        conv_start = 1'b1;
        state_next = BUSY;
      end
      BUSY: begin
        if (conv_done)           state_next = GAP;
        else if (cnt == TO_LAST) state_next = IDLE;
      end
      GAP: begin
        if (cnt == GAP_LAST) state_next = (scan_en && ch_mask != '0) ? ISSUE : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cur_ch      <= '0;
      prev_ch     <= '0;
      primed      <= 1'b0;
      cnt         <= '0;
      conv_conf   <= '0;
      scan_done   <= 1'b0;
      timeout_err <= 1'b0;
      valid       <= '0;
      for (int i = 0; i < NUM_CH; i++) result[i] <= '0;
    end else begin
      state     <= state_next;
      scan_done <= 1'b0;
      case (state)
        IDLE: begin
          primed <= 1'b0;
          if (state_next == ISSUE) begin
            cur_ch      <= pick_next;
            conv_conf   <= adc_conf(pick_next, uni, slp);
            timeout_err <= 1'b0;
          end
        end
        ISSUE: cnt <= '0;
        BUSY: begin
          cnt <= cnt + 1'b1;
          if (conv_done) begin
            // The returned data belongs to the frame configured before this one.
            if (primed) begin
              result[prev_ch] <= conv_data;
              valid[prev_ch]  <= 1'b1;
              scan_done       <= !pick_none && (prev_ch == pick_last);
            end
            prev_ch <= cur_ch;
            primed  <= 1'b1;
            cnt     <= '0;
            if (!pick_none) cur_ch <= pick_next;
          end else if (cnt == TO_LAST) begin
            timeout_err <= 1'b1;
          end
        end
        GAP: begin
          cnt <= cnt + 1'b1;
          if (state_next == ISSUE) conv_conf <= adc_conf(cur_ch, uni, slp);
        end
        default: ;
      endcase
    end
  end

  assign rd_data  = result[rd_ch];
  assign rd_valid = valid[rd_ch];

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Bench for adc_scan_sequencer: timeline reference model, ADC responder, directed
// scenarios with literal expectations and a randomized soak.
module tb_adc_scan_sequencer;

  localparam int G  = 4;
  localparam int TO = 40;
  localparam int DW = 12;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          scan_en = 1'b0;
  logic [7:0]    ch_mask = '0;
  logic          uni = 1'b0, slp = 1'b0;
  logic          conv_start;
  logic [5:0]    conv_conf;
  logic          conv_done = 1'b0;
  logic [DW-1:0] conv_data = '0;
  logic [2:0]    rd_ch = '0;
  logic [DW-1:0] rd_data;
  logic          rd_valid, scan_done, busy, timeout_err;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  adc_scan_sequencer #(.GAP_CYCLES(G), .TIMEOUT(TO), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .scan_en(scan_en), .ch_mask(ch_mask), .uni(uni), .slp(slp),
    .conv_start(conv_start), .conv_conf(conv_conf), .conv_done(conv_done), .conv_data(conv_data),
    .rd_ch(rd_ch), .rd_data(rd_data), .rd_valid(rd_valid), .scan_done(scan_done),
    .busy(busy), .timeout_err(timeout_err)
  );

  // ---------------- reference model: timeline of starts, frames and gaps ----------------
  int            cyc = 0, m_start = -1, m_next = -1, m_cur = 0, m_prev = 0;
  bit            m_act = 0, m_open = 0, m_primed = 0, m_sd = 0, m_err = 0;
  logic [5:0]    m_conf = '0;
  logic [DW-1:0] bank [8];
  bit            bval [8];

  function automatic logic [5:0] conf_of(input int ch, input logic u, input logic s);
    logic [2:0] c;
    c = 3'(ch);
    return {1'b1, c[0], c[2], c[1], u, s};
  endfunction

  function automatic int lowest(input logic [7:0] m);
    for (int i = 0; i < 8; i++) if (m[i]) return i;
    return 0;
  endfunction

  function automatic int highest(input logic [7:0] m);
    for (int i = 7; i >= 0; i--) if (m[i]) return i;
    return -1;
  endfunction

  function automatic int next_after(input logic [7:0] m, input int c);
    for (int k = 1; k <= 8; k++) if (m[(c + k) % 8]) return (c + k) % 8;
    return c;
  endfunction

  initial begin
    for (int i = 0; i < 8; i++) begin bank[i] = '0; bval[i] = 0; end
    forever begin
      @(posedge clk);
      cyc++;
      m_sd = 0;
      if (reset) begin
        m_act = 0; m_open = 0; m_primed = 0; m_err = 0; m_conf = '0;
        m_cur = 0; m_prev = 0; m_start = -1; m_next = -1;
        for (int i = 0; i < 8; i++) begin bank[i] = '0; bval[i] = 0; end
      end else if (!m_act) begin
        m_primed = 0;
        if (scan_en && ch_mask != 0) begin
          m_cur = lowest(ch_mask);
          m_err = 0;
          m_act = 1; m_open = 1; m_start = cyc; m_conf = conf_of(m_cur, uni, slp);
        end
      end else if (m_open && cyc - 1 > m_start) begin
        if (conv_done) begin
          if (m_primed) begin
            bank[m_prev] = conv_data;
            bval[m_prev] = 1;
            m_sd = (m_prev == highest(ch_mask));
          end
          m_prev = m_cur; m_primed = 1;
          m_cur = next_after(ch_mask, m_cur);
          m_open = 0; m_next = cyc + G;
        end else if (cyc - 1 == m_start + TO) begin
          m_err = 1; m_act = 0; m_open = 0;
        end
      end else if (!m_open && cyc == m_next) begin
        if (scan_en && ch_mask != 0) begin
          m_open = 1; m_start = cyc; m_conf = conf_of(m_cur, uni, slp);
        end else begin
          m_act = 0;
        end
      end
    end
  end

  // ---------------- ADC responder ----------------
  bit            withhold = 0, stray_en = 0, long_en = 0;
  int            lat_lo = 1, lat_hi = 5;
  int            force_cnt = 0, force_seen = 0;
  logic [DW-1:0] dtab [8];
  int            tab_len = 0, tab_gen = 0, seen_gen = 0, tpos = 0, pend = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (conv_start && !reset && !withhold) begin
        if (long_en && $urandom_range(0, 19) == 0) pend = TO + 3;
        else pend = $urandom_range(lat_lo, lat_hi);
      end
      @(posedge clk);
      #1;
      conv_done = 1'b0;
      if (tab_gen != seen_gen) begin seen_gen = tab_gen; tpos = 0; end
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          conv_done = 1'b1;
          if (tpos < tab_len) begin conv_data = dtab[tpos]; tpos++; end
          else conv_data = DW'($urandom);
        end
      end else if (force_cnt != force_seen) begin
        force_seen = force_cnt;
        conv_done = 1'b1;
        conv_data = DW'($urandom);
      end else if (stray_en && $urandom_range(0, 40) == 0) begin
        conv_done = 1'b1;
        conv_data = DW'($urandom);
      end
    end
  end

  // ---------------- checking helpers (all comparisons run in the main process) ----------------
  logic          s_start, s_busy, s_sd, s_err, s_rd_valid, s_done;
  logic [5:0]    s_conf;
  logic [DW-1:0] s_rd_data;
  int            sd_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      if (mismatched <= 40)
        $display("FAIL %s @cyc %0d: got 0x%0h, want 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic expire(input string name);
    compared++;
    mismatched++;
    $display("FAIL %s: bound expired @cyc %0d", name, cyc);
  endtask

  // One clock: sample and compare against the model on the falling edge, return at the drive point.
  task automatic tick();
    @(negedge clk);
    s_start = conv_start; s_conf = conv_conf; s_busy = busy; s_sd = scan_done;
    s_err = timeout_err; s_rd_data = rd_data; s_rd_valid = rd_valid; s_done = conv_done;
    if (!reset) begin
      chk("conv_start", 32'(conv_start), 32'(m_act && m_open && cyc == m_start));
      chk("conv_conf", 32'(conv_conf), 32'(m_conf));
      chk("busy", 32'(busy), 32'(m_act));
      chk("scan_done", 32'(scan_done), 32'(m_sd));
      chk("timeout_err", 32'(timeout_err), 32'(m_err));
      chk("rd_data", 32'(rd_data), 32'(bank[rd_ch]));
      chk("rd_valid", 32'(rd_valid), 32'(bval[rd_ch]));
      if (scan_done) sd_cnt++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_start(input string name);
    int n = 0;
    do begin tick(); n++; end while (!s_start && n < 200);
    if (!s_start) expire({name, "_start"});
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    do begin tick(); n++; end while (!s_done && n < 200);
    if (!s_done) expire({name, "_done"});
  endtask

  task automatic read_ch(input int ch);
    rd_ch = 3'(ch);
    tick();
  endtask

  task automatic reset_dut();
    scan_en = 0; withhold = 0; stray_en = 0; long_en = 0; lat_lo = 1; lat_hi = 5;
    reset = 1;
    tick(); tick();
    reset = 0;
    tick();
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sd0, n, nv;

    // Reset state
    tick(); tick();
    reset = 0;
    tick();
    chk("rst_busy", 32'(s_busy), 0);
    chk("rst_start", 32'(s_start), 0);
    chk("rst_conf", 32'(s_conf), 0);
    chk("rst_scan_done", 32'(s_sd), 0);
    chk("rst_err", 32'(s_err), 0);
    for (int ch = 0; ch < 8; ch++) begin
      read_ch(ch);
      chk("rst_valid", 32'(s_rd_valid), 0);
      chk("rst_data", 32'(s_rd_data), 0);
    end

    // Mask 05, one-frame result latency
    reset_dut();
    dtab[0] = 12'h111; dtab[1] = 12'hAAA; dtab[2] = 12'h333; tab_len = 3; tab_gen++;
    ch_mask = 8'h05; uni = 1; slp = 0; sd0 = sd_cnt;
    scan_en = 1;
    wait_start("m05_f1");
    chk("m05_conf_f1", 32'(s_conf), 32'(6'b100010));
    wait_done("m05_f1");
    read_ch(0);
    chk("m05_no_write_f1", 32'(s_rd_valid), 0);
    wait_start("m05_f2");
    chk("m05_conf_f2", 32'(s_conf), 32'(6'b100110));
    wait_done("m05_f2");
    wait_start("m05_f3");
    chk("m05_conf_f3", 32'(s_conf), 32'(6'b100010));
    wait_done("m05_f3");
    tick();
    read_ch(0);
    chk("m05_result0", 32'(s_rd_data), 32'h0AAA);
    chk("m05_valid0", 32'(s_rd_valid), 1);
    read_ch(2);
    chk("m05_result2", 32'(s_rd_data), 32'h0333);
    chk("m05_scan_done_cnt", 32'(sd_cnt - sd0), 1);

    // Single channel 7
    reset_dut();
    dtab[0] = 12'h101; dtab[1] = 12'h202; dtab[2] = 12'h303; dtab[3] = 12'h404; dtab[4] = 12'h505;
    tab_len = 5; tab_gen++;
    ch_mask = 8'h80; uni = 1; slp = 0; sd0 = sd_cnt;
    scan_en = 1;
    for (int f = 0; f < 5; f++) begin
      wait_start("m80");
      chk("m80_conf", 32'(s_conf), 32'(6'b111110));
      wait_done("m80");
    end
    tick();
    read_ch(7);
    chk("m80_result7", 32'(s_rd_data), 32'h0505);
    chk("m80_scan_done_cnt", 32'(sd_cnt - sd0), 4);
    tab_len = 0; tab_gen++;

    // Mask change from 03 to 10 during a frame
    reset_dut();
    ch_mask = 8'h03; uni = 1; slp = 0;
    scan_en = 1;
    for (int f = 0; f < 3; f++) begin wait_start("m03"); wait_done("m03"); end
    wait_start("m03_f4");
    ch_mask = 8'h10;
    wait_done("m03_f4");
    wait_start("m10_f5");
    chk("mchg_conf_ch4", 32'(s_conf), 32'(6'b101010));
    read_ch(0);
    chk("mchg_valid0", 32'(s_rd_valid), 1);
    read_ch(1);
    chk("mchg_valid1", 32'(s_rd_valid), 1);

    // Timeout with conv_done withheld, then restart clears the flag
    reset_dut();
    withhold = 1;
    ch_mask = 8'($urandom_range(1, 255));
    scan_en = 1;
    wait_start("to");
    scan_en = 0;
    repeat (TO + 2) tick();
    chk("to_err", 32'(s_err), 1);
    chk("to_idle", 32'(s_busy), 0);
    for (int ch = 0; ch < 8; ch++) begin
      read_ch(ch);
      chk("to_no_write", 32'(s_rd_valid), 0);
    end
    withhold = 0;
    scan_en = 1;
    wait_start("to_restart");
    chk("to_err_cleared", 32'(s_err), 0);

    // scan_en falls during a frame: store, gap, then idle
    wait_done("drop_f1");
    wait_start("drop_f2");
    scan_en = 0;
    wait_done("drop_f2");
    repeat (G) tick();
    chk("drop_busy_in_gap", 32'(s_busy), 1);
    tick();
    chk("drop_busy_off", 32'(s_busy), 0);
    n = 0;
    for (int c = 0; c < 30; c++) begin tick(); if (s_start) n++; end
    chk("drop_no_start", 32'(n), 0);
    nv = 0;
    for (int ch = 0; ch < 8; ch++) begin read_ch(ch); if (s_rd_valid) nv++; end
    chk("drop_stored", 32'(nv), 1);

    // Reset in the middle of a frame; late and stray done must be ignored
    reset_dut();
    lat_lo = 6; lat_hi = 6;
    ch_mask = 8'hFF;
    scan_en = 1;
    wait_start("rmid_f1");
    wait_done("rmid_f1");
    wait_start("rmid_f2");
    reset = 1; scan_en = 0;
    tick();
    chk("rmid_start", 32'(s_start), 0);
    chk("rmid_conf", 32'(s_conf), 0);
    chk("rmid_busy", 32'(s_busy), 0);
    chk("rmid_scan_done", 32'(s_sd), 0);
    chk("rmid_err", 32'(s_err), 0);
    reset = 0;
    repeat (8) tick();
    force_cnt++;
    repeat (3) tick();
    for (int ch = 0; ch < 8; ch++) begin
      read_ch(ch);
      chk("rmid_valid", 32'(s_rd_valid), 0);
    end

    // Randomized soak against the model
    reset_dut();
    stray_en = 1; long_en = 1; lat_lo = 1; lat_hi = 8;
    for (int r = 0; r < 14; r++) begin
      case (r % 4)
        0: ch_mask = 8'($urandom);
        1: ch_mask = 8'(1 << $urandom_range(0, 7));
        2: ch_mask = 8'($urandom) | 8'h81;
        default: ch_mask = 8'($urandom_range(0, 15));
      endcase
      uni = 1'($urandom); slp = 1'($urandom);
      scan_en = 1;
      for (int c = 0; c < 250; c++) begin
        rd_ch = 3'($urandom);
        if ($urandom_range(0, 49) == 0) ch_mask = 8'($urandom);
        if ($urandom_range(0, 99) == 0) scan_en = ~scan_en;
        if ($urandom_range(0, 149) == 0) uni = ~uni;
        if ($urandom_range(0, 149) == 0) slp = ~slp;
        tick();
      end
      if (r == 9) begin
        reset = 1; tick(); reset = 0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
